// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM states for the sequential ALU.
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_XOR  = 4'h4;
   localparam logic [3:0] OP_GTU  = 4'h5;
   localparam logic [3:0] OP_SHLA = 4'h6;
   localparam logic [3:0] OP_SHLB = 4'h7;
   localparam logic [3:0] OP_ADC  = 4'h8;
   localparam logic [3:0] OP_SBB  = 4'h9;
   localparam logic [3:0] OP_SHR  = 4'hA;
   localparam logic [3:0] OP_ASR  = 4'hB;
   localparam logic [3:0] OP_LTS  = 4'hC;
   localparam logic [3:0] OP_MUL  = 4'hD;
   localparam logic [3:0] OP_MULH = 4'hE;
   localparam logic [3:0] OP_RSVD = 4'hF;

   localparam int unsigned FLG_C   = 0;
   localparam int unsigned FLG_Z   = 1;
   localparam int unsigned FLG_GT  = 2;
   localparam int unsigned FLG_OVF = 3;

   typedef enum logic [1:0] {
      StIdle,
      StMul,
      StMdone
   } state_e;

   function automatic logic is_mul_op(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_MULH);
   endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier: one iteration per cycle, WIDTH iterations per start.
module alu_mul_seq #(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               done_o,
   output logic [2*WIDTH-1:0] prod_o
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic               run_q, run_d;
   logic [WIDTH:0]     sum;

   // High half accumulates; multiplier bits shift out of the low half.
   always_comb begin
      sum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
      done_o  = run_q && (cnt_q == CntW'(WIDTH - 1));
      mcand_d = mcand_q;
      prod_d  = prod_q;
      cnt_d   = cnt_q;
      run_d   = run_q;
      if (start_i) begin
         mcand_d = a_i;
         prod_d  = {{WIDTH{1'b0}}, b_i};
         cnt_d   = '0;
         run_d   = 1'b1;
      end else if (run_q) begin
         prod_d = {sum, prod_q[WIDTH-1:1]};
         cnt_d  = cnt_q + CntW'(1);
         if (done_o) begin
            run_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mcand_q <= '0;
         prod_q  <= '0;
         cnt_q   <= '0;
         run_q   <= 1'b0;
      end else begin
         mcand_q <= mcand_d;
         prod_q  <= prod_d;
         cnt_q   <= cnt_d;
         run_q   <= run_d;
      end
   end

   assign prod_o = prod_q;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result, persistent flags (ADC/SBB chains) and a
// sequential multiplier.
module alu_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [3:0]       out_flags,
   output logic             busy
);

   state_e             state_q, state_d;
   logic               valid_q, valid_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic [3:0]         flags_q, flags_d;
   logic               mul_hi_q, mul_gt_q;

   logic               accept, mul_start, mul_done;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   mul_res;

   logic               a_gt_b, c_in, cin, is_sub;
   logic [WIDTH-1:0]   b_x, alu_res;
   logic [WIDTH:0]     sum;
   logic               alu_c, alu_ovf;

   assign accept    = in_valid && in_ready;
   assign mul_start = accept && is_mul_op(in_op);
   assign mul_res   = mul_hi_q ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];

   alu_mul_seq #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (mul_start),
      .a_i     (in_a),
      .b_i     (in_b),
      .done_o  (mul_done),
      .prod_o  (prod)
   );

   assign a_gt_b = in_a > in_b;
   assign c_in   = flags_q[FLG_C];
   assign is_sub = (in_op == OP_SUB) || (in_op == OP_SBB);
   assign b_x    = is_sub ? ~in_b : in_b;

   always_comb begin
      case (in_op)
         OP_SUB:         cin = 1'b1;
         OP_ADC, OP_SBB: cin = c_in;
         default:        cin = 1'b0;
      endcase
   end

   assign sum = {1'b0, in_a} + {1'b0, b_x} + {{WIDTH{1'b0}}, cin};

   always_comb begin
      alu_res = '0;
      alu_c   = c_in;
      alu_ovf = 1'b0;
      case (in_op)
         OP_ADD, OP_SUB, OP_ADC, OP_SBB: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_ovf = (in_a[WIDTH-1] == b_x[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
         end
         OP_AND:  alu_res = in_a & in_b;
         OP_OR:   alu_res = in_a | in_b;
         OP_XOR:  alu_res = in_a ^ in_b;
         OP_GTU:  alu_res = WIDTH'(a_gt_b);
         OP_SHLA: begin
            alu_res = {in_a[WIDTH-2:0], 1'b0};
            alu_c   = in_a[WIDTH-1];
         end
         OP_SHLB: begin
            alu_res = {in_b[WIDTH-2:0], 1'b0};
            alu_c   = in_b[WIDTH-1];
         end
         OP_SHR: begin
            alu_res = {1'b0, in_a[WIDTH-1:1]};
            alu_c   = in_a[0];
         end
         OP_ASR: begin
            alu_res = {in_a[WIDTH-1], in_a[WIDTH-1:1]};
            alu_c   = in_a[0];
         end
         OP_LTS:  alu_res = WIDTH'($signed(in_a) < $signed(in_b));
         default: alu_res = '0;
      endcase
   end

   // Output register: drain first, then a load of either source wins.
   always_comb begin
      valid_d = valid_q;
      res_d   = res_q;
      flags_d = flags_q;
      if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
      if (state_q == StMdone) begin
         valid_d          = 1'b1;
         res_d            = mul_res;
         flags_d[FLG_Z]   = (mul_res == '0);
         flags_d[FLG_GT]  = mul_gt_q;
         flags_d[FLG_OVF] = 1'b0;
      end else if (accept && !is_mul_op(in_op)) begin
         valid_d          = 1'b1;
         res_d            = alu_res;
         flags_d[FLG_C]   = alu_c;
         flags_d[FLG_Z]   = (alu_res == '0);
         flags_d[FLG_GT]  = a_gt_b;
         flags_d[FLG_OVF] = alu_ovf;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         valid_q  <= 1'b0;
         res_q    <= '0;
         flags_q  <= '0;
         mul_hi_q <= 1'b0;
         mul_gt_q <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         res_q   <= res_d;
         flags_q <= flags_d;
         if (mul_start) begin
            mul_hi_q <= (in_op == OP_MULH);
            mul_gt_q <= a_gt_b;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (mul_start) state_d = StMul;
         StMul:   if (mul_done) state_d = StMdone;
         StMdone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      in_ready   = !rst && (state_q == StIdle) && (!valid_q || out_ready);
      busy       = (state_q == StMul) || (state_q == StMdone);
      out_valid  = valid_q;
      out_result = res_q;
      out_flags  = flags_q;
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8): cycle-by-cycle compare against an arithmetic
// model, plus literal expectations for each directed operation.
module tb_alu_seq;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [3:0]   in_op = '0;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] out_result;
   logic [3:0]   out_flags;
   logic         busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_seq #(
      .WIDTH (W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_flags  (out_flags),
      .busy       (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sgn(input int v);
      return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
   endfunction

   function automatic logic ovf_of(input int sr);
      return (sr < -(1 << (W - 1))) || (sr > (1 << (W - 1)) - 1);
   endfunction

   // Flags returned as {ovf, gt, zero, carry}.
   function automatic void model_op(input int op, input int a, input int b, input int c,
                                    output int res, output logic [3:0] fl);
      int mask;
      int nc;
      int bw;
      logic ov;
      mask = (1 << W) - 1;
      nc   = c;
      ov   = 1'b0;
      bw   = 1 - c;
      case (op)
         0: begin res = (a + b) & mask; nc = (a + b) >> W; ov = ovf_of(sgn(a) + sgn(b)); end
         8: begin
            res = (a + b + c) & mask; nc = (a + b + c) >> W;
            ov = ovf_of(sgn(a) + sgn(b) + c);
         end
         1: begin res = (a - b) & mask; nc = int'(a >= b); ov = ovf_of(sgn(a) - sgn(b)); end
         9: begin
            res = (a - b - bw) & mask; nc = int'(a >= b + bw);
            ov = ovf_of(sgn(a) - sgn(b) - bw);
         end
         2:  res = a & b;
         3:  res = a | b;
         4:  res = a ^ b;
         5:  res = int'(a > b);
         6:  begin res = (a * 2) & mask; nc = a >> (W - 1); end
         7:  begin res = (b * 2) & mask; nc = b >> (W - 1); end
         10: begin res = a / 2; nc = a % 2; end
         11: begin res = (sgn(a) >>> 1) & mask; nc = a % 2; end
         12: res = int'(sgn(a) < sgn(b));
         13: res = (a * b) & mask;
         14: res = (a * b) >> W;
         default: res = 0;
      endcase
      fl[3] = ov;
      fl[2] = a > b;
      fl[1] = (res == 0);
      fl[0] = (nc & 1) != 0;
   endfunction

   // Model state: m_left counts edges until a pending multiply result lands.
   int       m_left = 0;
   logic     m_valid = 1'b0;
   int       m_res = 0;
   logic [3:0] m_flags = '0;
   int       m_pres = 0;
   logic [3:0] m_pfl = '0;

   always @(posedge clk or posedge rst) begin : model
      int r;
      logic [3:0] f;
      logic rdy;
      logic nv;
      int nres, nleft;
      logic [3:0] nfl;
      if (rst) begin
         m_left  <= 0;
         m_valid <= 1'b0;
         m_res   <= 0;
         m_flags <= '0;
      end else begin
         nv    = m_valid;
         nres  = m_res;
         nfl   = m_flags;
         nleft = m_left;
         rdy   = (m_left == 0) && (!m_valid || out_ready);
         if (m_valid && out_ready) nv = 1'b0;
         if (m_left > 0) begin
            nleft = m_left - 1;
            if (nleft == 0) begin
               nv = 1'b1; nres = m_pres; nfl = m_pfl;
            end
         end else if (in_valid && rdy) begin
            model_op(int'(in_op), int'(in_a), int'(in_b), int'(m_flags[0]), r, f);
            if (in_op == 4'hD || in_op == 4'hE) begin
               m_pres <= r;
               m_pfl  <= f;
               nleft  = W + 1;
            end else begin
               nv = 1'b1; nres = r; nfl = f;
            end
         end
         m_valid <= nv;
         m_res   <= nres;
         m_flags <= nfl;
         m_left  <= nleft;
      end
   end

   always @(negedge clk) begin
      chk("in_ready", 32'(in_ready), 32'(!rst && m_left == 0 && (!m_valid || out_ready)));
      chk("busy", 32'(busy), 32'(m_left > 0));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid || rst) begin
         chk("out_result", 32'(out_result), 32'(m_res));
         chk("out_flags", 32'(out_flags), 32'(m_flags));
      end
   end

   // lat = edges after the accept edge until out_valid; busy is expected for lat samples.
   task automatic issue(input string name, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] er, input logic [3:0] ef,
                        input int lat);
      int n;
      int bc;
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #2; n++;
      end
      chk({name, " accept_timeout"}, 32'(n >= 50), 32'(0));
      @(posedge clk); #2;
      in_valid = 1'b0;
      in_op = 4'($urandom); in_a = 8'($urandom); in_b = 8'($urandom);
      n = 0;
      bc = busy ? 1 : 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #2; n++;
         if (busy) bc++;
      end
      chk({name, " latency"}, 32'(n), 32'(lat));
      chk({name, " busy_cycles"}, 32'(bc), 32'(lat));
      chk({name, " result"}, 32'(out_result), 32'(er));
      chk({name, " flags"}, 32'(out_flags), 32'(ef));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      chk("rst in_ready", 32'(in_ready), 32'(0));
      chk("rst out_valid", 32'(out_valid), 32'(0));
      chk("rst out_result", 32'(out_result), 32'(0));
      chk("rst out_flags", 32'(out_flags), 32'(0));
      chk("rst busy", 32'(busy), 32'(0));
      rst = 1'b0;
      #1 chk("post-rst in_ready", 32'(in_ready), 32'(1));
      @(posedge clk); #2;

      // Flags literal order is {ovf, gt, zero, carry}.
      issue("ADD wrap", 4'h0, 8'hFF, 8'h01, 8'h00, 4'b0111, 0);
      issue("ADD chain", 4'h0, 8'hFF, 8'h02, 8'h01, 4'b0101, 0);
      issue("ADC chain", 4'h8, 8'h00, 8'h00, 8'h01, 4'b0000, 0);
      issue("SUB borrow", 4'h1, 8'h05, 8'h07, 8'hFE, 4'b0000, 0);
      issue("SBB borrow", 4'h9, 8'h00, 8'h00, 8'hFF, 4'b0000, 0);
      issue("ADD setc", 4'h0, 8'hFF, 8'h01, 8'h00, 4'b0111, 0);
      issue("MUL", 4'hD, 8'h10, 8'h20, 8'h00, 4'b0011, 9);
      issue("MULH", 4'hE, 8'h10, 8'h20, 8'h02, 4'b0001, 9);
      issue("ADC after MUL", 4'h8, 8'h00, 8'h00, 8'h01, 4'b0000, 0);
      issue("ASR", 4'hB, 8'h81, 8'h00, 8'hC0, 4'b0101, 0);
      issue("SHR", 4'hA, 8'h81, 8'h00, 8'h40, 4'b0101, 0);
      issue("LTS", 4'hC, 8'h80, 8'h01, 8'h01, 4'b0101, 0);
      issue("GTU", 4'h5, 8'h80, 8'h01, 8'h01, 4'b0101, 0);
      issue("RSVD", 4'hF, 8'h00, 8'h00, 8'h00, 4'b0011, 0);
      issue("AND", 4'h2, 8'hF0, 8'h3C, 8'h30, 4'b0101, 0);
      issue("OR zero", 4'h3, 8'h00, 8'h00, 8'h00, 4'b0011, 0);
      issue("SHL A", 4'h6, 8'h81, 8'h00, 8'h02, 4'b0101, 0);
      issue("SHL B", 4'h7, 8'h00, 8'h40, 8'h80, 4'b0000, 0);
      issue("ADD ovf", 4'h0, 8'h7F, 8'h01, 8'h80, 4'b1100, 0);
      issue("MUL big", 4'hD, 8'hFF, 8'hFF, 8'h01, 4'b0000, 9);
      issue("MULH big", 4'hE, 8'hFF, 8'hFE, 8'hFD, 4'b0100, 9);

      // Backpressure: result held while the consumer stalls.
      @(posedge clk); #2;
      out_ready = 1'b0;
      in_valid = 1'b1; in_op = 4'h4; in_a = 8'h0F; in_b = 8'hFF;
      @(posedge clk); #2;
      chk("bp first valid", 32'(out_valid), 32'(1));
      chk("bp first result", 32'(out_result), 32'(8'hF0));
      in_op = 4'h1; in_a = 8'h01; in_b = 8'h01;
      for (int i = 0; i < 3; i++) begin
         chk("bp in_ready low", 32'(in_ready), 32'(0));
         chk("bp result held", 32'(out_result), 32'(8'hF0));
         chk("bp flags held", 32'(out_flags), 32'(4'b0000));
         @(posedge clk); #2;
      end
      out_ready = 1'b1;
      #1 chk("bp in_ready release", 32'(in_ready), 32'(1));
      @(posedge clk); #2;
      in_valid = 1'b0;
      chk("bp second valid", 32'(out_valid), 32'(1));
      chk("bp second result", 32'(out_result), 32'(8'h00));
      chk("bp second flags", 32'(out_flags), 32'(4'b0011));

      // Reset during the fourth cycle of a multiply.
      in_valid = 1'b1; in_op = 4'hD; in_a = 8'h03; in_b = 8'h05;
      @(posedge clk); #2;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("midmul busy", 32'(busy), 32'(1));
      rst = 1'b1;
      #1;
      chk("midmul rst out_valid", 32'(out_valid), 32'(0));
      chk("midmul rst out_result", 32'(out_result), 32'(0));
      chk("midmul rst out_flags", 32'(out_flags), 32'(0));
      chk("midmul rst busy", 32'(busy), 32'(0));
      chk("midmul rst in_ready", 32'(in_ready), 32'(0));
      @(posedge clk); #2;
      rst = 1'b0;
      #1 chk("after rst in_ready", 32'(in_ready), 32'(1));
      repeat (12) @(posedge clk);
      #2;
      chk("no stale result", 32'(out_valid), 32'(0));
      issue("ADC after rst", 4'h8, 8'h01, 8'h01, 8'h02, 4'b0000, 0);

      @(posedge clk); #2;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's 8-bit combinational ALU. It has a registered result, a persistent flags register that makes multi-word ADC/SBB chains possible, right shifts and a signed compare, and a sequential shift-add multiplier. It sits between an operand source and a result consumer, with valid/ready handshakes on both sides. Opcodes 0000–0111 keep the legacy 3-bit encoding, with op[3]=0.

## Interface
- `WIDTH`, default 8: operand and result width. Legal range is 2 or more.
- `clk`  in  1  the single clock. All state changes on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  1  an operation is presented.
- `in_ready`  out  1  equals `state==IDLE && (!out_valid || out_ready)`.
- `in_op`  in  4  opcode (see Operation).
- `in_a`, `in_b`  in  WIDTH  operands.
- `out_valid`  out  1  `out_result` and `out_flags` are valid.
- `out_ready`  in  1  the consumer accepts the result.
- `out_result`  out  WIDTH  result register.
- `out_flags`  out  4  snapshot of `{ovf, gt, zero, carry}`, taken when the result was loaded.
- `busy`  out  1  high while the multiplier is in state MUL or MDONE.

## Operation
- **Accept:** an operation is accepted on a rising edge when `in_valid && in_ready`.
- **Output drain:** the output register drains on a rising edge when `out_valid && out_ready`.
- **Opcodes:**
  - 0000 ADD: A+B.
  - 0001 SUB: A+~B+1.
  - 0010 AND.
  - 0011 OR.
  - 0100 XOR.
  - 0101 GTU: result 1 if A>B unsigned, else 0.
  - 0110 SHL A by 1.
  - 0111 SHL B by 1.
  - 1000 ADC: A+B+C.
  - 1001 SBB: A+~B+C.
  - 1010 SHR A, logical, by 1.
  - 1011 ASR A by 1.
  - 1100 LTS: result 1 if A<B signed, else 0.
  - 1101 MUL: low WIDTH bits of the unsigned product.
  - 1110 MULH: high WIDTH bits of the unsigned product.
  - 1111 reserved: result 0.
- **C** is the registered carry flag. Subtraction uses the convention carry=1 means no borrow.
- **Flags register** `{ovf, gt, zero, carry}` is updated only when the output register is loaded:
  - carry:
    - ADD/SUB/ADC/SBB: adder carry-out.
    - SHL: the MSB shifted out.
    - SHR/ASR: the LSB shifted out.
    - All other ops: unchanged.
  - zero: `result == 0`, for every op.
  - gt: A>B unsigned, for every op.
  - ovf: signed overflow for ADD/SUB/ADC/SBB; 0 for every other op.
- **State machine:** IDLE → MUL (exactly WIDTH cycles, one shift-add iteration per cycle) → MDONE (1 cycle) → IDLE.
  - Only opcodes 1101 and 1110 leave IDLE.
  - All other opcodes load the output register on the accept edge.
  - MDONE loads the output register and flags. The output register is guaranteed empty at that point, because it was empty or draining at accept time and `in_ready` stays low throughout MUL and MDONE.
- **Flags for MUL/MULH:** ADC/SBB following a MUL/MULH see the unchanged carry.
- **Arithmetic width:** the adder is WIDTH+1 bits, and carry is bit WIDTH. The product register is 2·WIDTH bits. The iteration counter is `$clog2(WIDTH+1)` bits.

## Timing
- **Reset values:**
  - `out_valid` = 0, `out_result` = 0, `out_flags` = 0.
  - Flags register = 0, state = IDLE, `busy` = 0.
  - `in_ready` = 0 while `rst` is high.
  - Reset asserted mid-MUL aborts the operation with no output. `in_ready` = 1 in the first cycle after reset deasserts.
- **Single-cycle ops:** latency 1. `out_valid` is high after the accept edge. Throughput is one op per cycle while `out_ready` = 1.
- **MUL/MULH:** latency WIDTH+1 edges (9 for WIDTH=8). `in_ready` is low for WIDTH+1 cycles after the accept edge.
- **Backpressure:** while `out_valid && !out_ready`, `out_result` and `out_flags` hold stable and `in_ready` = 0.
- **Simultaneous drain and accept:** a new single-cycle result overwrites the register on the same edge, and `out_valid` stays 1.
- **Flag dependency:** an op accepted on the edge after a flag-producing load sees the updated C.
- **Unchanged inputs:** `in_a`, `in_b` and `in_op` need not be held after acceptance. Operands are captured on the accept edge.

## Structure
- **Shared package `alu_pkg`** holds:
  - opcode localparams (`OP_ADD` … `OP_MULH`, `OP_RSVD`);
  - flag bit indices (`FLG_C`=0, `FLG_Z`=1, `FLG_GT`=2, `FLG_OVF`=3);
  - state encodings.
- **Sub-module `alu_mul_seq`:** sequential shift-add multiplier with a start/done pulse interface, parametrised by WIDTH. The top module owns the handshake, the flags register and the output register.

## Test plan (WIDTH=8)
- **ADD with wrap:** ADD 0xFF+0x01 → result 0x00, flags C=1, Z=1, GT=1, OVF=0. `out_valid` is high one cycle after accept.
- **Carry chain:** ADD 0xFF+0x02 → 0x01, C=1. Then ADC 0x00+0x00 → 0x01, C=0. Then SUB 0x05−0x07 → 0xFE, C=0. Then SBB 0x00−0x00 → 0xFF, C=0.
- **Multiply:** MUL 0x10×0x20 → 0x00, Z=1, C unchanged. MULH with the same operands → 0x02. `out_valid` rises 9 edges after accept. `busy`=1 and `in_ready`=0 for 9 cycles.
- **Backpressure:** hold `out_ready`=0 for 3 cycles with a result pending → `out_result` stable and `in_ready`=0. The next op is accepted on the edge where `out_ready`=1.
- **Reset mid-multiply:** assert `rst` in cycle 4 of a MUL → all outputs reset immediately. After deassert: `in_ready`=1, no stale result.
- **Shifts and compares:** ASR 0x81 → 0xC0, C=1. SHR 0x81 → 0x40, C=1. LTS 0x80,0x01 → 0x01. GTU 0x80,0x01 → 0x01. Reserved 0xF → 0x00, Z=1.
